vga_timing_ctrl: RTL and testbench

Generates the 640x480@60 VGA pixel schedule from the 50 MHz system clock.
- A fractional phase accumulator produces an average 25.175 MHz pixel-enable pulse (pix_tick); the block does not generate a derived clock.
- Horizontal and vertical FSMs sequence the visible, front-porch, sync and back-porch intervals.
- Outputs are pixel coordinates, syncs, blanking and frame/line markers for the pixel generator and the RGB output stage.

---
 rtl/vga_timing_ctrl.sv | 130 +++++++++++++
 tb/tb_vga_timing_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 pixel schedule from the system clock.
// A fractional phase accumulator produces a pixel-enable pulse. Horizontal and
// vertical FSMs walk the visible/front-porch/sync/back-porch intervals, and all
// outputs are registered so they agree with each other while pix_tick is high.
module vga_timing_ctrl #(
    parameter int ACC_W     = 16,
    parameter int PHASE_INC = 32998,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       pix_tick,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_BP_START   = 10'(H_VISIBLE + H_FP + H_SYNC);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_BP_START   = 10'(V_VISIBLE + V_FP + V_SYNC);

    localparam logic [ACC_W:0] INC      = (ACC_W + 1)'(PHASE_INC);
    localparam logic           SYNC_ACT = 1'(SYNC_POL);

    typedef enum logic [1:0] {ST_HACT, ST_HFP, ST_HSYNC, ST_HBP} h_state_t;
    typedef enum logic [1:0] {ST_VACT, ST_VFP, ST_VSYNC, ST_VBP} v_state_t;

    h_state_t         h_state, h_state_nxt;
    v_state_t         v_state, v_state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             h_wrap;
    logic [9:0]       h_nxt;
    logic [9:0]       v_nxt;

    // Accumulator sum and carry; a dropped enable suppresses the carry.
    always_comb begin
        sum   = {1'b0, acc} + INC;
        carry = enable & sum[ACC_W];
    end

    // Counter values and FSM states that the next tick would move to.
    always_comb begin
        h_wrap      = (hcount == H_LAST);
        h_nxt       = h_wrap ? '0 : hcount + 10'd1;
        v_nxt       = vcount;
        if (h_wrap) begin
            v_nxt = (vcount == V_LAST) ? '0 : vcount + 10'd1;
        end

        h_state_nxt = h_state;
        case (h_state)
            ST_HACT:  if (h_nxt == H_FP_START)   h_state_nxt = ST_HFP;
            ST_HFP:   if (h_nxt == H_SYNC_START) h_state_nxt = ST_HSYNC;
            ST_HSYNC: if (h_nxt == H_BP_START)   h_state_nxt = ST_HBP;
            ST_HBP:   if (h_nxt == '0)           h_state_nxt = ST_HACT;
            default:                             h_state_nxt = ST_HBP;
        endcase

        v_state_nxt = v_state;
        if (h_wrap) begin
            case (v_state)
                ST_VACT:  if (v_nxt == V_FP_START)   v_state_nxt = ST_VFP;
                ST_VFP:   if (v_nxt == V_SYNC_START) v_state_nxt = ST_VSYNC;
                ST_VSYNC: if (v_nxt == V_BP_START)   v_state_nxt = ST_VBP;
                ST_VBP:   if (v_nxt == '0)           v_state_nxt = ST_VACT;
                default:                             v_state_nxt = ST_VBP;
            endcase
        end
    end

    // Accumulator, counters, FSMs and registered outputs; everything moves on a tick edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            hcount      <= H_LAST;
            vcount      <= V_LAST;
            h_state     <= ST_HBP;
            v_state     <= ST_VBP;
            hsync       <= ~SYNC_ACT;
            vsync       <= ~SYNC_ACT;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_tick    <= carry;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (enable) begin
                acc <= sum[ACC_W-1:0];
            end
            if (carry) begin
                hcount      <= h_nxt;
                vcount      <= v_nxt;
                h_state     <= h_state_nxt;
                v_state     <= v_state_nxt;
                hsync       <= (h_state_nxt == ST_HSYNC) ? SYNC_ACT : ~SYNC_ACT;
                vsync       <= (v_state_nxt == ST_VSYNC) ? SYNC_ACT : ~SYNC_ACT;
                video_on    <= (h_state_nxt == ST_HACT) && (v_state_nxt == ST_VACT);
                line_start  <= (h_nxt == '0);
                frame_start <= (h_nxt == '0) && (v_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: randomized enable stimulus against an arithmetic model
// (tick = accumulator overflow, position = linear pixel index within a frame).
// Expected outputs for each tick are queued; a monitor pops them on pix_tick.
// A reduced raster geometry is used so many whole frames fit in the run.
module tb_vga_timing_ctrl;

    localparam int ACC_W = 16;
    localparam int INC   = 32998;
    localparam int HV = 16, HFP = 4, HS = 6, HBP = 6;
    localparam int VV = 8,  VFP = 2, VS = 2, VBP = 3;
    localparam int SP = 0;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int MOD = 1 << ACC_W;

    typedef struct {
        int h;
        int v;
        int hs;
        int vs;
        int von;
        int ls;
        int fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pix_tick;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       line_start;
    logic       frame_start;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];
    int   acc_m;
    int   pos_m;
    int   last_h;
    int   last_v;

    vga_timing_ctrl #(
        .ACC_W(ACC_W), .PHASE_INC(INC),
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(SP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .line_start(line_start), .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int p);
        exp_t e;
        e.h   = p % HT;
        e.v   = p / HT;
        e.hs  = (e.h >= HV + HFP && e.h < HV + HFP + HS) ? SP : 1 - SP;
        e.vs  = (e.v >= VV + VFP && e.v < VV + VFP + VS) ? SP : 1 - SP;
        e.von = (e.h < HV && e.v < VV) ? 1 : 0;
        e.ls  = (e.h == 0) ? 1 : 0;
        e.fs  = (p == 0) ? 1 : 0;
        return e;
    endfunction

    // One clock: advance the model on the edge, then set enable for the next edge.
    task automatic cycle(input bit en_next);
        int s;
        @(posedge clk);
        if (!reset && enable) begin
            s     = acc_m + INC;
            acc_m = s % MOD;
            if (s >= MOD) begin
                pos_m = (pos_m + 1) % FRAME;
                q.push_back(mk(pos_m));
            end
        end
        #2 enable = en_next;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_hcount"}, int'(hcount), HT - 1);
        chk({tag, "_vcount"}, int'(vcount), VT - 1);
        chk({tag, "_hsync"}, int'(hsync), 1 - SP);
        chk({tag, "_vsync"}, int'(vsync), 1 - SP);
        chk({tag, "_video_on"}, int'(video_on), 0);
        chk({tag, "_pix_tick"}, int'(pix_tick), 0);
        chk({tag, "_line_start"}, int'(line_start), 0);
        chk({tag, "_frame_start"}, int'(frame_start), 0);
    endtask

    // Monitor: pop an expectation on every tick; between ticks the position must hold.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            last_h = HT - 1;
            last_v = VT - 1;
        end else if (pix_tick) begin
            if (q.size() == 0) begin
                chk("unexpected_tick", 1, 0);
            end else begin
                e = q.pop_front();
                chk("hcount", int'(hcount), e.h);
                chk("vcount", int'(vcount), e.v);
                chk("hsync", int'(hsync), e.hs);
                chk("vsync", int'(vsync), e.vs);
                chk("video_on", int'(video_on), e.von);
                chk("line_start", int'(line_start), e.ls);
                chk("frame_start", int'(frame_start), e.fs);
                last_h = e.h;
                last_v = e.v;
            end
        end else begin
            chk("missing_tick", q.size(), 0);
            chk("hold_hcount", int'(hcount), last_h);
            chk("hold_vcount", int'(vcount), last_v);
            chk("idle_line_start", int'(line_start), 0);
            chk("idle_frame_start", int'(frame_start), 0);
        end
    end

    initial begin
        int k;
        reset  = 1'b1;
        enable = 1'b0;
        acc_m  = 0;
        pos_m  = FRAME - 1;
        #1;
        chk_reset_values("por");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset_held");
        @(negedge clk);
        #3 reset = 1'b0;

        // Fully enabled start: first tick on the second edge lands at (0,0).
        for (int i = 0; i < 200; i++) cycle(1'b1);
        for (int i = 0; i < 3000; i++) cycle($urandom_range(0, 7) != 0);

        // Freeze mid-line at hcount 20 for 50 clocks, then resume.
        k = 0;
        while (k < 2000 && !(pos_m % HT == 20 && q.size() != 0)) begin
            cycle(1'b1);
            k++;
        end
        chk("freeze_target_reached", int'(pos_m % HT == 20), 1);
        enable = 1'b0;
        for (int i = 0; i < 50; i++) cycle(1'b0);
        for (int i = 0; i < 3000; i++) cycle($urandom_range(0, 7) != 0);

        // Async reset mid-vsync, during the horizontal back porch.
        k = 0;
        while (k < 3000 && pos_m != (VV + VFP + 1) * HT + 28) begin
            cycle(1'b1);
            k++;
        end
        chk("reset_target_reached", pos_m, (VV + VFP + 1) * HT + 28);
        @(negedge clk);
        chk("pre_reset_vsync", int'(vsync), SP);
        #3 reset = 1'b1;
        acc_m = 0;
        pos_m = FRAME - 1;
        #1;
        chk_reset_values("async_reset");
        for (int i = 0; i < 3; i++) cycle(1'b1);
        @(negedge clk);
        #3 reset = 1'b0;

        for (int i = 0; i < 6000; i++) cycle($urandom_range(0, 15) != 0);
        for (int i = 0; i < 4000; i++) cycle(1'b1);
        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
